// File: rtl/if_byte_reader.sv
// Reader endpoint for the shared 8-bit interface bus.
// Captures writer bytes through a valid/ready handshake into a
// small first-word-fall-through FIFO and hands them to the local
// consumer through a second valid/ready port.
//
// Ports:
//   i_clk      clock, all state changes on its rising edge
//   i_arst     synchronous active-high reset
//   en         block enable, low freezes all state
//   i_y_valid  writer presents a byte on i_y
//   i_y        bus data from the writer
//   o_y_ready  reader can accept a byte this cycle
//   o_b        head-of-FIFO byte to the consumer
//   o_b_valid  o_b holds a valid byte
//   i_b_ready  consumer takes o_b this cycle
//   o_count    FIFO occupancy, 0..DEPTH
//   o_ovf      sticky overflow flag, set on a write attempt while full
module if_byte_reader #(
  parameter  int DW    = 8,
  parameter  int DEPTH = 4,
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic          i_clk,
  input  logic          i_arst,
  input  logic          en,
  input  logic          i_y_valid,
  input  logic [DW-1:0] i_y,
  output logic          o_y_ready,
  output logic [DW-1:0] o_b,
  output logic          o_b_valid,
  input  logic          i_b_ready,
  output logic [CW-1:0] o_count,
  output logic          o_ovf
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          ovf;

  logic full;
  logic empty;
  logic push;
  logic pop;

  // Full/empty come only from the count; the pointers alone
  // cannot tell the two apart once they wrap.
  assign full  = (count == FULL);
  assign empty = (count == '0);

  // Ready never looks at i_y_valid, so no loop can form through
  // the writer.
  assign o_y_ready = en & ~full;
  assign o_b_valid = en & ~empty;

  assign push = i_y_valid & o_y_ready;
  assign pop  = o_b_valid & i_b_ready;

  // Head is shown regardless of valid; no bypass from i_y.
  assign o_b     = mem[rd_ptr];
  assign o_count = count;
  assign o_ovf   = ovf;

  always_ff @(posedge i_clk) begin
    if (i_arst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (push) begin
        mem[wr_ptr] <= i_y;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      unique case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      // Any offer while full is recorded, even one that a same
      // cycle pop will make room for on the next edge.
      if (en && i_y_valid && full) begin
        ovf <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_if_byte_reader.sv
// Directed self-checking bench for if_byte_reader.
// Walks through reset, FWFT latency, streaming, overflow and enable.
module tb_if_byte_reader;

  localparam int DW = 8;
  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          arst;
  logic          en;
  logic          y_valid;
  logic [DW-1:0] y;
  logic          y_ready;
  logic [DW-1:0] b;
  logic          b_valid;
  logic          b_ready;
  logic [CW-1:0] count;
  logic          ovf;

  int checks = 0;
  int errors = 0;

  if_byte_reader #(.DW(DW), .DEPTH(4)) dut (
    .i_clk     (clk),
    .i_arst    (arst),
    .en        (en),
    .i_y_valid (y_valid),
    .i_y       (y),
    .o_y_ready (y_ready),
    .o_b       (b),
    .o_b_valid (b_valid),
    .i_b_ready (b_ready),
    .o_count   (count),
    .o_ovf     (ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [DW-1:0] v);
    y_valid = 1'b1;
    y       = v;
    step();
    y_valid = 1'b0;
  endtask

  task automatic drain(input string tag,
                       input logic [DW-1:0] first,
                       input int n);
    b_ready = 1'b1;
    for (int i = 0; i < n; i++) begin
      chk({tag, "_valid"}, 32'(b_valid), 32'd1);
      chk({tag, "_data"}, 32'(b), 32'(first + DW'(i)));
      step();
    end
    b_ready = 1'b0;
    chk({tag, "_empty"}, 32'(count), 32'd0);
  endtask

  initial begin
    int got_n;
    arst    = 1'b1;
    en      = 1'b1;
    y_valid = 1'b0;
    y       = '0;
    b_ready = 1'b0;
    step();
    step();
    arst = 1'b0;

    chk("rst_ready", 32'(y_ready), 32'd1);
    chk("rst_valid", 32'(b_valid), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    chk("rst_b", 32'(b), 32'd0);

    // single byte appears one edge after the push
    push(8'hA5);
    chk("t1_valid", 32'(b_valid), 32'd1);
    chk("t1_b", 32'(b), 32'hA5);
    chk("t1_count", 32'(count), 32'd1);
    chk("t1_ready", 32'(y_ready), 32'd1);
    drain("t1_drain", 8'hA5, 1);

    // streaming push and pop with pointer wrap
    got_n   = 0;
    b_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      y_valid = (i < 10);
      y       = 8'h10 + DW'(i);
      step();
      chk("t3_cnt_le1", 32'(count <= 1), 32'd1);
      if (b_valid) begin
        chk("t3_order", 32'(b), 32'(8'h10 + DW'(got_n)));
        got_n++;
      end
    end
    y_valid = 1'b0;
    b_ready = 1'b0;
    chk("t3_n", 32'(got_n), 32'd10);
    chk("t3_ovf", 32'(ovf), 32'd0);

    // fill, overflow attempt, drain
    for (int i = 1; i <= 4; i++) push(DW'(i));
    chk("t2_count", 32'(count), 32'd4);
    chk("t2_ready", 32'(y_ready), 32'd0);
    push(8'h05);
    chk("t2_ovf", 32'(ovf), 32'd1);
    chk("t2_count_held", 32'(count), 32'd4);
    drain("t2_drain", 8'h01, 4);
    chk("t2_ovf_sticky", 32'(ovf), 32'd1);

    // full with offer and pop in the same cycle
    for (int i = 0; i < 4; i++) push(8'h20 + DW'(i));
    y_valid = 1'b1;
    y       = 8'h24;
    b_ready = 1'b1;
    step();
    b_ready = 1'b0;
    chk("t4_pop_only", 32'(count), 32'd3);
    chk("t4_ready", 32'(y_ready), 32'd1);
    step();
    y_valid = 1'b0;
    chk("t4_refill", 32'(count), 32'd4);
    drain("t4_drain", 8'h21, 4);

    // enable low freezes everything
    push(8'h31);
    push(8'h32);
    en = 1'b0;
    y  = 8'h99;
    #1;
    chk("t5_ready", 32'(y_ready), 32'd0);
    chk("t5_valid", 32'(b_valid), 32'd0);
    for (int k = 0; k < 3; k++) begin
      y_valid = (k % 2 == 0);
      b_ready = (k % 2 != 0);
      step();
      chk("t5_count", 32'(count), 32'd2);
      chk("t5_valid_lo", 32'(b_valid), 32'd0);
    end
    y_valid = 1'b0;
    en      = 1'b1;
    #1;
    drain("t5_drain", 8'h31, 2);

    // reset beats a concurrent push and pop
    for (int i = 0; i < 3; i++) push(8'h41 + DW'(i));
    chk("t6_pre_ovf", 32'(ovf), 32'd1);
    chk("t6_pre_cnt", 32'(count), 32'd3);
    arst    = 1'b1;
    y_valid = 1'b1;
    y       = 8'h44;
    b_ready = 1'b1;
    step();
    arst    = 1'b0;
    y_valid = 1'b0;
    chk("t6_count", 32'(count), 32'd0);
    chk("t6_valid", 32'(b_valid), 32'd0);
    chk("t6_ovf", 32'(ovf), 32'd0);
    chk("t6_b", 32'(b), 32'd0);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("t6_no_old", 32'(b_valid), 32'd0);
    end
    b_ready = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/if_byte_reader.md
Name: if_byte_reader

Overview:
- Reader-side endpoint for the shared 8-bit interface bus between a writer module and its consumers.
- Replaces the transparent-latch capture (`en`-gated) with a clocked valid/ready handshake on the bus side and a small first-word-fall-through (FWFT) FIFO.
- Delivers captured bytes to the local consumer through a second valid/ready port.
- Sits between the writer instance and the downstream `o_b` logic in `top`.

Parameters:
- DW, 8, data width of the interface bus and of the output.
- DEPTH, 4, FIFO depth in entries; must be a power of 2 and at least 2.
- CW, $clog2(DEPTH)+1, occupancy counter width; derived, not overridden.

Ports:
- i_clk  input  1  sole clock; all state updates on its rising edge.
- i_arst  input  1  synchronous reset, active-high; sampled on the `i_clk` rising edge.
- en  input  1  block enable; low freezes all state.
- i_y_valid  input  1  writer presents a byte on `i_y`.
- i_y  input  DW  interface bus data from the writer.
- o_y_ready  output  1  reader can accept a byte this cycle.
- o_b  output  DW  head-of-FIFO data to the consumer.
- o_b_valid  output  1  `o_b` holds a valid byte.
- i_b_ready  input  1  consumer accepts `o_b` this cycle.
- o_count  output  CW  current FIFO occupancy, 0..DEPTH.
- o_ovf  output  1  sticky overflow flag.

Behaviour:
- Reset: `i_arst` high at a clock edge sets write pointer, read pointer and count to 0, and clears `o_ovf`.
  - In the cycle after reset: `o_y_ready` = `en`, `o_b_valid` = 0, `o_count` = 0, `o_ovf` = 0, `o_b` = 0.
  - Storage is also cleared to 0.
- Reset has priority over every other event, including a push or pop in the same cycle.
- Reset mid-transfer discards all stored bytes; no partial state survives.
- `o_y_ready` = `en` & (count != DEPTH); combinational from registered count.
- `o_b_valid` = `en` & (count != 0).
- `o_b` = mem[rd_ptr], valid or not; when empty it shows the last popped value or the reset value.
- Push = `i_y_valid` & `o_y_ready`.
  - Writes `i_y` to mem[wr_ptr]; wr_ptr increments modulo DEPTH.
- Pop = `o_b_valid` & `i_b_ready`.
  - rd_ptr increments modulo DEPTH.
- Count update: +1 on push only, -1 on pop only, unchanged on both or neither.
- Latency: a byte pushed at edge N appears on `o_b` with `o_b_valid` = 1 after edge N, if the FIFO was empty. That is one cycle, with no bypass path.
- Simultaneous push and pop:
  - Not full: both occur and count is unchanged.
  - Full: ready is low, so only the pop occurs. Ready rises the next cycle; there is no same-cycle refill when full.
  - Empty: valid is low, so only the push occurs.
- Pointer wrap: pointers are log2(DEPTH) bits and wrap naturally. Full/empty are determined by count, never by pointer comparison.
- Overflow: at an edge where `en` = 1, `i_y_valid` = 1 and count == DEPTH, `o_ovf` is set to 1.
  - The offered byte is dropped.
  - `o_ovf` stays 1 until reset.
  - The writer is expected to hold valid; the flag still records any attempt while full.
- `en` = 0:
  - `o_y_ready` = 0 and `o_b_valid` = 0.
  - No push, no pop, no overflow detection.
  - Pointers, count, storage and `o_ovf` are held.
  - `o_count` continues to show the held count.
  - Re-asserting `en` resumes with the FIFO contents intact.
- Handshake rules for the bus side:
  - The writer must keep `i_y` stable while `i_y_valid` is high and ready is low.
  - The reader never depends on `i_y_valid` to drive `o_y_ready`, so there is no combinational loop.
- No latches; every storage element is an edge-triggered flop on `i_clk`.

Test Plan:
- Reset, then `en` = 1, push 0xA5 with `i_b_ready` = 0 → the next cycle `o_b_valid` = 1, `o_b` = 0xA5, `o_count` = 1, `o_y_ready` = 1.
- Push 0x01, 0x02, 0x03, 0x04 back-to-back with `i_b_ready` = 0 → `o_count` = 4, `o_y_ready` = 0. A fifth valid with 0x05 sets `o_ovf` = 1 and 0x05 is never output. Draining yields 0x01..0x04 in order, and `o_ovf` remains 1.
- Continuous push and pop, `i_b_ready` = 1, 10 bytes 0x10..0x19 → output order 0x10..0x19, pointers wrap twice, `o_count` never exceeds 1, `o_ovf` = 0.
- Full FIFO with `i_y_valid` = 1 and `i_b_ready` = 1 in the same cycle → a pop only, `o_count` 4→3, and the offered byte is accepted the following cycle, giving `o_count` = 4 again.
- Fill 2 entries, drop `en` for 3 cycles while toggling `i_y_valid` and `i_b_ready` → `o_y_ready` = 0, `o_b_valid` = 0, `o_count` = 2 held. After `en` returns high, the same 2 bytes drain in order.
- Fill 3 entries with `o_ovf` set, assert `i_arst` concurrently with push and pop for 1 cycle → next cycle `o_count` = 0, `o_b_valid` = 0, `o_ovf` = 0, `o_b` = 0, and none of the old bytes are output.
